// File: rtl/coffee_status_encoder.sv
// Coffee machine status encoder: debounced inputs, order FSM, CODE valid/ack producer.
// Optional build macro STICKY_ERR_EN: errors latch until confirm M with all sensor faults clear.

module coffee_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1, sync2;
    logic [DW-1:0] cnt;

    // Counting only while the synced value differs from the level makes any glitch restart the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (cnt == DEB_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Pulse on the cycle the level is about to rise, so the FSM reacts on the same edge.
    assign rise = sync2 & ~level & (cnt == DEB_LAST);
endmodule

module coffee_status_encoder #(
    parameter int DEB_CYCLES     = 50000,
    parameter int HOLD_CYCLES    = 100000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       S0,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       SR,
    input  logic       SP,
    input  logic       SN,
    input  logic       VL,
    input  logic       M,
    input  logic       CODE_ACK,
    output logic [3:0] CODE,
    output logic       CODE_VALID
);
    localparam int NIN  = 9;
    localparam int TMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TSAT      = {TW{1'b1}};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHOW  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    // Index map: 0-3 drink buttons, 4 confirm, 5 SR, 6 SP, 7 SN, 8 VL.
    logic [NIN-1:0] raw, deb, rise;
    assign raw = {VL, SN, SP, SR, M, S3, S2, S1, S0};

    for (genvar i = 0; i < NIN; i++) begin : g_deb
        coffee_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (CLK),
            .rst  (RST),
            .raw  (raw[i]),
            .level(deb[i]),
            .rise (rise[i])
        );
    end

    logic          btn_hit, m_rise, flt_sr, flt_sp, flt_sn, vl_ok;
    logic [1:0]    btn_idx;
    logic [2:0]    state, state_n;
    logic [1:0]    sel, sel_n;
    logic [3:0]    code_n;
    logic [TW-1:0] tmr;
    logic          tmr_clr;

    assign btn_hit = |rise[3:0];
    assign m_rise  = rise[4];
    assign flt_sr  = deb[5];
    assign flt_sp  = deb[6];
    assign flt_sn  = deb[7];
    assign vl_ok   = deb[8];

    always_comb begin
        btn_idx = 2'd3;
        if      (rise[0]) btn_idx = 2'd0;
        else if (rise[1]) btn_idx = 2'd1;
        else if (rise[2]) btn_idx = 2'd2;
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        code_n  = CODE;
        tmr_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                code_n = 4'd0;
                if (btn_hit) begin
                    state_n = ST_SHOW;
                    sel_n   = btn_idx;
                    code_n  = {2'b00, btn_idx} + 4'd1;
                end
            end
            ST_SHOW: begin
                if (btn_hit) begin
                    sel_n   = btn_idx;
                    code_n  = {2'b00, btn_idx} + 4'd1;
                    tmr_clr = 1'b1;
                end else if (m_rise) begin
                    state_n = ST_CHECK;
                end else if (tmr == TO_LAST) begin
                    state_n = ST_IDLE;
                    code_n  = 4'd0;
                end
            end
            ST_CHECK: begin
                state_n = ST_ERROR;
                if      (flt_sr) code_n = 4'd5;
                else if (flt_sp) code_n = 4'd6;
                else if (flt_sn) code_n = 4'd7;
                else if (!vl_ok) code_n = 4'd8;
                else             state_n = ST_DONE;
            end
            ST_DONE: begin
                if (tmr == HOLD_LAST) begin
                    state_n = ST_IDLE;
                    code_n  = 4'd0;
                end
            end
            ST_ERROR: begin
`ifdef STICKY_ERR_EN
                if (m_rise && !(flt_sr || flt_sp || flt_sn)) begin
                    state_n = ST_IDLE;
                    code_n  = 4'd0;
                end
`else
                if (tmr == HOLD_LAST) begin
                    state_n = ST_IDLE;
                    code_n  = 4'd0;
                end
`endif
            end
            default: begin
                state_n = ST_IDLE;
                code_n  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            sel   <= 2'd0;
            tmr   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            if (tmr_clr || (state_n != state)) tmr <= '0;
            else if (tmr != TSAT)              tmr <= tmr + 1'b1;
        end
    end

    // A code change always re-arms VALID and wins over an ACK in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CODE       <= 4'd0;
            CODE_VALID <= 1'b0;
        end else if (code_n != CODE) begin
            CODE       <= code_n;
            CODE_VALID <= 1'b1;
        end else if (CODE_VALID && CODE_ACK) begin
            CODE_VALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_coffee_status_encoder.sv
// Bench for coffee_status_encoder: directed scenarios plus randomized orders against a rule model.
module tb_coffee_status_encoder;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int TO   = 50;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] btn = 4'd0;
    logic       sr = 0, sp = 0, sn = 0, vl = 0, m = 0, ack = 0;
    logic [3:0] code;
    logic       valid;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 CLK = ~CLK;

    coffee_status_encoder #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .S0(btn[0]), .S1(btn[1]), .S2(btn[2]), .S3(btn[3]),
        .SR(sr), .SP(sp), .SN(sn), .VL(vl), .M(m),
        .CODE_ACK(ack), .CODE(code), .CODE_VALID(valid)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        btn = 0; sr = 0; sp = 0; sn = 0; vl = 0; m = 0; ack = 0;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        tick(1);
        n_cmp++; if (code !== 4'd0 || valid !== 1'b0) begin n_err++; $display("FAIL reset_state: code=%0d valid=%0b want 0/0", code, valid); end
        RST = 1'b0;
        btn = 4'b0010;
        tick(6);
        n_cmp++; if (code !== 4'd2) begin n_err++; $display("FAIL reset_presel: code=%0d want 2", code); end
        btn = 0;
        tick(2);
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (code !== 4'd0 || valid !== 1'b0) begin n_err++; $display("FAIL reset_async: code=%0d valid=%0b want 0/0", code, valid); end
        tick(1);
        RST = 1'b0;
        tick(10);
        n_cmp++; if (code !== 4'd0 || valid !== 1'b0) begin n_err++; $display("FAIL reset_release: code=%0d valid=%0b want 0/0", code, valid); end
    endtask

    task automatic test_debounce();
        do_reset();
        btn[2] = 1; tick(3); btn[2] = 0; tick(10);
        n_cmp++; if (code !== 4'd0 || valid !== 1'b0) begin n_err++; $display("FAIL deb_glitch: code=%0d valid=%0b want 0/0", code, valid); end
        btn[2] = 1;
        tick(5);
        n_cmp++; if (code !== 4'd0) begin n_err++; $display("FAIL deb_early: code=%0d want 0", code); end
        tick(1);
        n_cmp++; if (code !== 4'd3 || valid !== 1'b1) begin n_err++; $display("FAIL deb_latency: code=%0d valid=%0b want 3/1", code, valid); end
        tick(4);
        btn[2] = 0;
        ack = 1; tick(1); ack = 0;
        n_cmp++; if (valid !== 1'b0 || code !== 4'd3) begin n_err++; $display("FAIL ack_clear: code=%0d valid=%0b want 3/0", code, valid); end
        ack = 1; tick(1); ack = 0;
        n_cmp++; if (valid !== 1'b0 || code !== 4'd3) begin n_err++; $display("FAIL ack_idle: code=%0d valid=%0b want 3/0", code, valid); end
    endtask

    task automatic test_select_done();
        do_reset();
        vl = 1; tick(8);
        btn = 4'b1001; tick(6);
        n_cmp++; if (code !== 4'd1) begin n_err++; $display("FAIL prio_s0_s3: code=%0d want 1", code); end
        btn = 0; ack = 1; tick(1); ack = 0; tick(8);
        btn = 4'b0010; tick(6);
        n_cmp++; if (code !== 4'd2 || valid !== 1'b1) begin n_err++; $display("FAIL reselect: code=%0d valid=%0b want 2/1", code, valid); end
        btn = 0;
        m = 1; tick(6);
        n_cmp++; if (code !== 4'd2) begin n_err++; $display("FAIL check_code: code=%0d want 2", code); end
        tick(1);
        ack = 1; btn = 4'b0001; tick(1); ack = 0; m = 0;
        n_cmp++; if (valid !== 1'b0 || code !== 4'd2) begin n_err++; $display("FAIL done_ack: code=%0d valid=%0b want 2/0", code, valid); end
        tick(10); btn = 0; tick(8);
        n_cmp++; if (code !== 4'd2) begin n_err++; $display("FAIL done_hold: code=%0d want 2", code); end
        tick(1);
        n_cmp++; if (code !== 4'd0 || valid !== 1'b1) begin n_err++; $display("FAIL done_exit: code=%0d valid=%0b want 0/1", code, valid); end
    endtask

    task automatic test_fault_priority();
        do_reset();
        sp = 1; sn = 1; tick(8);
        btn[1] = 1; tick(6); btn = 0;
        ack = 1; tick(1); ack = 0; tick(7);
        m = 1; tick(7);
        n_cmp++; if (code !== 4'd6 || valid !== 1'b1) begin n_err++; $display("FAIL sp_over_sn: code=%0d valid=%0b want 6/1", code, valid); end
        m = 0;
`ifdef STICKY_ERR_EN
        tick(20);
        n_cmp++; if (code !== 4'd6) begin n_err++; $display("FAIL sticky_hold: code=%0d want 6", code); end
`else
        tick(19);
        n_cmp++; if (code !== 4'd6) begin n_err++; $display("FAIL err_hold: code=%0d want 6", code); end
        tick(1);
        n_cmp++; if (code !== 4'd0 || valid !== 1'b1) begin n_err++; $display("FAIL err_exit: code=%0d valid=%0b want 0/1", code, valid); end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        vl = 1; tick(8);
        btn[3] = 1; tick(6);
        n_cmp++; if (code !== 4'd4) begin n_err++; $display("FAIL to_sel: code=%0d want 4", code); end
        tick(10); btn = 0; tick(39);
        n_cmp++; if (code !== 4'd4) begin n_err++; $display("FAIL to_before: code=%0d want 4", code); end
        tick(1);
        n_cmp++; if (code !== 4'd0) begin n_err++; $display("FAIL to_exit: code=%0d want 0", code); end
        vl = 0; tick(8);
        btn[3] = 1; tick(6);
        m = 1; tick(7);
        n_cmp++; if (code !== 4'd8) begin n_err++; $display("FAIL no_money: code=%0d want 8", code); end
        btn = 0; m = 0; tick(8);
    endtask

    task automatic test_error_exit();
        do_reset();
        sr = 1; vl = 1; tick(8);
        btn[0] = 1; tick(6); btn = 0;
        m = 1; tick(7);
        n_cmp++; if (code !== 4'd5) begin n_err++; $display("FAIL err_sr: code=%0d want 5", code); end
        m = 0;
`ifdef STICKY_ERR_EN
        tick(100);
        n_cmp++; if (code !== 4'd5) begin n_err++; $display("FAIL sticky_long: code=%0d want 5", code); end
        m = 1; tick(10);
        n_cmp++; if (code !== 4'd5) begin n_err++; $display("FAIL sticky_m_fault: code=%0d want 5", code); end
        m = 0; sr = 0; tick(10);
        m = 1; tick(5);
        n_cmp++; if (code !== 4'd5) begin n_err++; $display("FAIL sticky_pre: code=%0d want 5", code); end
        tick(1);
        n_cmp++; if (code !== 4'd0) begin n_err++; $display("FAIL sticky_exit: code=%0d want 0", code); end
        m = 0;
`else
        tick(8); m = 1; tick(11);
        n_cmp++; if (code !== 4'd5) begin n_err++; $display("FAIL err_m_ignored: code=%0d want 5", code); end
        tick(1);
        n_cmp++; if (code !== 4'd0) begin n_err++; $display("FAIL err_exit_m: code=%0d want 0", code); end
        m = 0;
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int        sel, exp_code, gb, gl;
            logic [3:0] mask;
            logic       do_ack, exp_valid;
            do_reset();
            sr = ($urandom_range(0, 4) == 0);
            sp = ($urandom_range(0, 4) == 0);
            sn = ($urandom_range(0, 4) == 0);
            vl = ($urandom_range(0, 3) != 0);
            gb = $urandom_range(0, 3);
            gl = $urandom_range(1, DEB - 1);
            btn[gb] = 1; tick(gl); btn = 0; tick(8);
            n_cmp++; if (code !== 4'd0 || valid !== 1'b0) begin n_err++; $display("FAIL rnd_glitch[%0d]: code=%0d valid=%0b want 0/0", it, code, valid); end
            mask = 4'($urandom_range(1, 15));
            sel = 3;
            for (int b = 3; b >= 0; b--) if (mask[b]) sel = b;
            btn = mask; tick(6); btn = 0;
            n_cmp++; if (code !== 4'(sel + 1) || valid !== 1'b1) begin n_err++; $display("FAIL rnd_sel[%0d]: code=%0d valid=%0b want %0d/1", it, code, valid, sel + 1); end
            do_ack = 1'($urandom_range(0, 1));
            ack = do_ack; tick(1); ack = 0; tick(7);
            exp_valid = !do_ack;
            m = 1; tick(7); m = 0;
            exp_code = sr ? 5 : sp ? 6 : sn ? 7 : !vl ? 8 : sel + 1;
            if (exp_code != sel + 1) exp_valid = 1'b1;
            n_cmp++; if (code !== 4'(exp_code) || valid !== exp_valid) begin n_err++; $display("FAIL rnd_result[%0d]: code=%0d valid=%0b want %0d/%0b", it, code, valid, exp_code, exp_valid); end
            tick(19);
            n_cmp++; if (code !== 4'(exp_code)) begin n_err++; $display("FAIL rnd_hold[%0d]: code=%0d want %0d", it, code, exp_code); end
            tick(1);
`ifdef STICKY_ERR_EN
            if (exp_code >= 5) exp_code = exp_code; else exp_code = 0;
`else
            exp_code = 0;
`endif
            n_cmp++; if (code !== 4'(exp_code) || valid !== 1'b1) begin n_err++; $display("FAIL rnd_exit[%0d]: code=%0d valid=%0b want %0d/1", it, code, valid, exp_code); end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_select_done();
        test_fault_priority();
        test_timeout();
        test_error_exit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
